// File: rtl/axis_fifo_pkg.sv
// Shared pieces of the AXI-Stream packet FIFO: address-width helper, mode
// encodings and the stored beat layout (last flag packed above the data).
`define AXIS_FIFO_BEAT_T(W) struct packed { logic last; logic [(W)-1:0] data; }

package axis_fifo_pkg;

    localparam int PKT_STORE_FWD = 1;

    function automatic int aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// The read register holds its value when re is low and is the only reset state.
module sdp_ram
    import axis_fifo_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 2048,
    parameter int AW    = aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with optional store-and-forward packet mode. The RAM read
// register doubles as the output register, so a read lands directly on m_*.
module axis_pkt_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DW       = 8,
    parameter int DEPTH    = 2048,
    parameter int PKT_MODE = 0,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic [DW-1:0]          m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] pkt_count,
    output logic                   almost_full,
    output logic                   almost_empty
);

    localparam int AW        = aw(DEPTH);
    localparam int CW        = AW + 1;
    localparam bit STORE_FWD = (PKT_MODE == PKT_STORE_FWD);

    typedef `AXIS_FIFO_BEAT_T(DW) beat_t;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, ram_cnt;
    logic [CW-1:0] pkt_q, pkt_d, pkt_ram_q, pkt_ram_d, pkt_ram_eff;
    logic          m_tvalid_q, m_tvalid_d;
    logic          rd_vld_q, run_q;
    logic          esc_q, esc_d, esc_set, esc_eff;
    logic          full, wr_fire, m_fire, rd_en, rd_allow, last_out;
    beat_t         wbeat, rbeat;

    assign full     = (count_q == CW'(DEPTH));
    // run_q keeps the input closed for one cycle after reset releases
    assign s_tready = run_q && !full && !rst;
    assign wr_fire  = s_tvalid && s_tready;
    assign m_fire   = m_tvalid_q && m_tready;
    assign ram_cnt  = count_q - CW'(m_tvalid_q);

    // A tlast beat read last cycle is only visible now; retire it early so
    // the gate does not let the next, still-open packet through.
    assign last_out    = rd_vld_q && rbeat.last;
    assign pkt_ram_eff = pkt_ram_q - CW'(last_out);
    assign esc_eff     = esc_q && !last_out;
    assign esc_set     = full && (pkt_q == '0);

    always_comb begin
        rd_allow = 1'b1;
        if (STORE_FWD) rd_allow = (pkt_ram_eff != '0) || esc_eff || full;
    end

    assign rd_en = (ram_cnt != '0) && rd_allow && (!m_tvalid_q || m_tready);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(wr_fire);
        rd_ptr_d   = rd_ptr_q + AW'(rd_en);
        count_d    = count_q + CW'(wr_fire) - CW'(m_fire);
        m_tvalid_d = rd_en ? 1'b1 : (m_fire ? 1'b0 : m_tvalid_q);
        pkt_d      = '0;
        pkt_ram_d  = '0;
        esc_d      = 1'b0;
        if (STORE_FWD) begin
            pkt_d     = pkt_q + CW'(wr_fire && s_tlast) - CW'(m_fire && rbeat.last);
            pkt_ram_d = pkt_ram_eff + CW'(wr_fire && s_tlast);
            // Oversized packet filled the RAM: drain it until its tlast leaves
            esc_d     = esc_set || esc_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_q      <= '0;
            pkt_ram_q  <= '0;
            m_tvalid_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            esc_q      <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pkt_q      <= pkt_d;
            pkt_ram_q  <= pkt_ram_d;
            m_tvalid_q <= m_tvalid_d;
            rd_vld_q   <= rd_en;
            esc_q      <= esc_d;
            run_q      <= 1'b1;
        end
    end

    assign wbeat.last = s_tlast;
    assign wbeat.data = s_tdata;

    sdp_ram #(
        .W     ($bits(beat_t)),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire),
        .waddr (wr_ptr_q),
        .wdata (wbeat),
        .re    (rd_en),
        .raddr (rd_ptr_q),
        .rdata (rbeat)
    );

    assign m_tvalid     = m_tvalid_q;
    assign m_tdata      = rbeat.data;
    assign m_tlast      = rbeat.last;
    assign count        = count_q;
    assign pkt_count    = pkt_q;
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: a cut-through and a store-and-forward instance,
// each checked cycle by cycle against a queue-based reference.
module tb_axis_pkt_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          c_rst = 1'b1, c_sv = 1'b0, c_sl = 1'b0, c_mr = 1'b0;
    logic [DW-1:0] c_sd = '0, c_md;
    logic          c_st, c_mv, c_ml, c_af, c_ae;
    logic [CW-1:0] c_cnt, c_pc;

    logic          p_rst = 1'b1, p_sv = 1'b0, p_sl = 1'b0, p_mr = 1'b0;
    logic [DW-1:0] p_sd = '0, p_md;
    logic          p_st, p_mv, p_ml, p_af, p_ae;
    logic [CW-1:0] p_cnt, p_pc;

    axis_pkt_fifo #(.DW(DW), .DEPTH(DEPTH), .PKT_MODE(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_ct (
        .clk(clk), .rst(c_rst), .s_tdata(c_sd), .s_tvalid(c_sv), .s_tlast(c_sl), .s_tready(c_st),
        .m_tdata(c_md), .m_tvalid(c_mv), .m_tlast(c_ml), .m_tready(c_mr),
        .count(c_cnt), .pkt_count(c_pc), .almost_full(c_af), .almost_empty(c_ae));

    axis_pkt_fifo #(.DW(DW), .DEPTH(DEPTH), .PKT_MODE(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_pk (
        .clk(clk), .rst(p_rst), .s_tdata(p_sd), .s_tvalid(p_sv), .s_tlast(p_sl), .s_tready(p_st),
        .m_tdata(p_md), .m_tvalid(p_mv), .m_tlast(p_ml), .m_tready(p_mr),
        .count(p_cnt), .pkt_count(p_pc), .almost_full(p_af), .almost_empty(p_ae));

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    typedef struct { logic [DW-1:0] d; logic l; int t; } mbeat_t;
    mbeat_t cq[$];
    mbeat_t pq[$];
    int     cyc = 0;
    bit     c_live = 0, c_hold = 0;
    int     c_first_mv = -1;
    bit     p_live = 0, p_stall = 0;
    logic [DW-1:0] p_pd;
    logic   p_pl;
    int     p_out = 0;

    // Cut-through reference: a beat accepted in cycle t is presented from t+2
    // onwards once everything older has been delivered.
    task automatic ct_tick(input bit r, input bit sv, input logic [DW-1:0] sd,
                           input bit sl, input bit mr, output bit acc);
        bit wr, rd, ev;
        mbeat_t b;
        @(posedge clk); #1;
        c_rst = r; c_sv = sv; c_sd = sd; c_sl = sl; c_mr = mr;
        cyc++;
        @(negedge clk);
        wr = c_sv && c_st;
        rd = c_mv && c_mr;
        ev = (cq.size() != 0) ? (cq[0].t <= cyc - 2) : 1'b0;
        if (c_live) begin
            chk("ct_s_tready", c_st, int'(!r && !c_hold && cq.size() != DEPTH));
            chk("ct_count", c_cnt, cq.size());
            chk("ct_m_tvalid", c_mv, ev);
            if (ev) begin
                chk("ct_m_tdata", c_md, cq[0].d);
                chk("ct_m_tlast", c_ml, cq[0].l);
            end
            chk("ct_almost_full", c_af, int'(cq.size() >= AF));
            chk("ct_almost_empty", c_ae, int'(cq.size() <= AE));
            chk("ct_pkt_count", c_pc, 0);
        end
        if (c_mv && c_first_mv < 0) c_first_mv = cyc;
        acc = wr && !r;
        if (r) begin
            cq.delete();
            c_hold = 1;
            c_live = 1;
        end else begin
            c_hold = 0;
            if (rd && cq.size() != 0) void'(cq.pop_front());
            if (wr) begin
                b.d = sd; b.l = sl; b.t = cyc;
                cq.push_back(b);
            end
        end
    endtask

    // Store-and-forward reference: in-order scoreboard, exact count, AXI hold.
    task automatic pk_tick(input bit r, input bit sv, input logic [DW-1:0] sd,
                           input bit sl, input bit mr, output bit acc);
        bit wr, rd;
        mbeat_t b;
        @(posedge clk); #1;
        p_rst = r; p_sv = sv; p_sd = sd; p_sl = sl; p_mr = mr;
        cyc++;
        @(negedge clk);
        wr = p_sv && p_st && !r;
        rd = p_mv && p_mr;
        if (p_live) begin
            chk("pk_count", p_cnt, pq.size());
            if (p_stall) begin
                chk("pk_hold_valid", p_mv, 1);
                chk("pk_hold_data", p_md, p_pd);
                chk("pk_hold_last", p_ml, p_pl);
            end
            if (rd) begin
                if (pq.size() == 0) chk("pk_spurious_valid", p_mv, 0);
                else begin
                    chk("pk_m_tdata", p_md, pq[0].d);
                    chk("pk_m_tlast", p_ml, pq[0].l);
                    void'(pq.pop_front());
                    p_out++;
                end
            end
        end
        p_stall = p_live && !r && p_mv && !p_mr;
        p_pd = p_md;
        p_pl = p_ml;
        acc = wr;
        if (r) begin
            pq.delete();
            p_live  = 1;
            p_stall = 0;
        end else if (wr) begin
            b.d = sd; b.l = sl; b.t = cyc;
            pq.push_back(b);
        end
    endtask

    // One packet of n beats with a gap before tlast; nothing may leave before tlast+2.
    task automatic pk_packet(input int n, input int gap, input logic [DW-1:0] base);
        bit a;
        p_out = 0;
        for (int i = 0; i < n - 1; i++) begin
            pk_tick(0, 1, base + DW'(i), 0, 1, a);
            chk("pk_body_accept", a, 1);
            chk("pk_gate_body", p_mv, 0);
        end
        for (int i = 0; i < gap; i++) begin
            pk_tick(0, 0, '0, 0, 1, a);
            chk("pk_gate_gap", p_mv, 0);
        end
        pk_tick(0, 1, base + DW'(n - 1), 1, 1, a);
        chk("pk_tlast_accept", a, 1);
        chk("pk_gate_tlast", p_mv, 0);
        for (int k = 1; k <= n + 3; k++) begin
            pk_tick(0, 0, '0, 0, 1, a);
            chk("pk_m_tvalid_window", p_mv, int'(k >= 2 && k <= n + 1));
            chk("pk_pkt_count", p_pc, int'(k >= 1 && k <= n + 1));
        end
        chk("pk_delivered", p_out, n);
    endtask

    initial begin
        bit a, v, l, seen;
        int n, t_acc, len, sent, guard;
        logic [DW-1:0] d;

        // Cut-through: reset state
        ct_tick(1, 0, '0, 0, 0, a);
        ct_tick(0, 0, '0, 0, 0, a);
        chk("ct_rst_m_tdata", c_md, 0);
        chk("ct_rst_m_tlast", c_ml, 0);
        chk("ct_rst_s_tready", c_st, 0);

        // 16-beat stream with the sink always ready
        n = 0; t_acc = -1; c_first_mv = -1;
        for (int i = 0; i < 100 && n < 16; i++) begin
            ct_tick(0, 1, DW'(n), n == 15, 1, a);
            if (a) begin
                if (t_acc < 0) t_acc = cyc;
                n++;
            end
        end
        chk("ct_stream_accepts", n, 16);
        for (int i = 0; i < 6; i++) ct_tick(0, 0, '0, 0, 1, a);
        chk("ct_first_latency", c_first_mv - t_acc, 2);
        chk("ct_drain_count", c_cnt, 0);
        chk("ct_drain_almost_empty", c_ae, 1);

        // Fill against a stalled sink, then a single read reopens the input
        n = 0;
        for (int i = 0; i < 20; i++) begin
            ct_tick(0, 1, DW'(8'hA0 + n), 0, 0, a);
            if (a) n++;
        end
        chk("ct_fill_accepts", n, 16);
        chk("ct_full_count", c_cnt, 16);
        chk("ct_full_s_tready", c_st, 0);
        chk("ct_full_almost_full", c_af, 1);
        ct_tick(0, 1, DW'(8'hA0 + n), 0, 1, a);
        chk("ct_full_read_no_write", a, 0);
        ct_tick(0, 1, DW'(8'hA0 + n), 0, 0, a);
        chk("ct_s_tready_after_read", c_st, 1);
        chk("ct_refill_accept", a, 1);
        for (int i = 0; i < 24; i++) ct_tick(0, 0, '0, 0, 1, a);
        chk("ct_fill_drained", c_cnt, 0);

        // Random traffic, random packet lengths 1..40
        v = 0; l = 0; d = '0; len = 0; sent = 0; guard = 0;
        while (sent < 10000 && guard < 60000) begin
            if (!v && $urandom_range(1) == 1) begin
                v = 1;
                d = DW'($urandom);
                if (len == 0) len = $urandom_range(40, 1);
                len--;
                l = (len == 0);
            end
            ct_tick(0, v, d, l, $urandom_range(1) == 1, a);
            if (a) begin
                v = 0;
                sent++;
            end
            guard++;
        end
        chk("ct_random_sent", sent, 10000);
        for (int i = 0; i < 24; i++) ct_tick(0, 0, '0, 0, 1, a);
        chk("ct_random_drained", c_cnt, 0);

        // Reset with 7 beats held and m_tvalid high
        for (int i = 0; i < 7; i++) ct_tick(0, 1, DW'(8'hE0 + i), i == 6, 0, a);
        ct_tick(0, 0, '0, 0, 0, a);
        chk("ct_pre_rst_valid", c_mv, 1);
        chk("ct_pre_rst_count", c_cnt, 7);
        ct_tick(1, 0, '0, 0, 0, a);
        ct_tick(0, 0, '0, 0, 1, a);
        chk("ct_post_rst_valid", c_mv, 0);
        chk("ct_post_rst_count", c_cnt, 0);
        chk("ct_post_rst_s_tready", c_st, 0);
        ct_tick(0, 0, '0, 0, 1, a);
        chk("ct_post_rst_s_tready_1", c_st, 1);
        for (int i = 0; i < 4; i++) ct_tick(0, 1, DW'(8'h50 + i), i == 3, 1, a);
        for (int i = 0; i < 6; i++) ct_tick(0, 0, '0, 0, 1, a);
        chk("ct_post_rst_drained", c_cnt, 0);

        // Store-and-forward: reset, gated packet
        pk_tick(1, 0, '0, 0, 0, a);
        pk_tick(0, 0, '0, 0, 0, a);
        chk("pk_rst_pkt_count", p_pc, 0);
        chk("pk_rst_almost_empty", p_ae, 1);
        chk("pk_rst_almost_full", p_af, 0);
        chk("pk_rst_s_tready", p_st, 0);
        pk_packet(5, 3, 8'h10);

        // Oversized packet forces the deadlock escape
        n = 0; seen = 0; p_out = 0;
        for (int i = 0; i < 200 && n < 20; i++) begin
            pk_tick(0, 1, DW'(8'h40 + n), n == 19, 1, a);
            if (a) n++;
            if (p_cnt == CW'(DEPTH)) seen = 1;
        end
        chk("pk_big_accepts", n, 20);
        chk("pk_big_filled", seen, 1);
        for (int i = 0; i < 24; i++) pk_tick(0, 0, '0, 0, 1, a);
        chk("pk_big_delivered", p_out, 20);
        chk("pk_big_count", p_cnt, 0);
        chk("pk_big_pkt_count", p_pc, 0);

        // Gating resumes after the escape
        pk_packet(3, 2, 8'h70);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
